// File: rtl/dma_arb_pkg.sv
// Shared types for the DMA request arbiter: sequencer states and op encoding.
package dma_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first request at or after ptr, with wrap.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_id,
  output logic          any
);

  int idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = PW'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_req_arbiter.sv
// Round-robin front end for the single-beat DMA engine: one transaction in flight,
// enable pulse, wait for done or timeout, then hand the response back to its owner.
module dma_req_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         eng_s2mm_en,
  output logic                         eng_mm2s_en,
  output logic [ADDR_WIDTH-1:0]        eng_addr,
  output logic [DATA_WIDTH-1:0]        eng_wdata,
  input  logic                         eng_done,
  input  logic [DATA_WIDTH-1:0]        eng_rdata,
  input  logic                         eng_err,
  output logic                         busy,
  output logic [15:0]                  timeout_cnt
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(TIMEOUT_CYC);

  arb_state_t            state_q, state_d;
  logic [IDW-1:0]        id_q, id_d, rr_ptr_q, rr_ptr_d;
  logic                  op_q, op_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [15:0]           tcnt_q, tcnt_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IDW-1:0]        grant_id;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rr_arbiter #(.N(NUM_REQ), .PW(IDW)) u_rr (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  assign sel_addr  = req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    id_d     = id_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rr_ptr_d = rr_ptr_q;
    tcnt_d   = tcnt_q;
    timer_d  = '0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          id_d    = grant_id;
          op_d    = req_write[grant_id];
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          rdata_d = '0;
          err_d   = (sel_addr[1:0] != 2'b00);
          state_d = (sel_addr[1:0] != 2'b00) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        // The ISSUE cycle is tick 0, so the timeout lands TIMEOUT_CYC cycles after the pulse.
        timer_d = TW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          rdata_d = (op_q == OP_READ) ? eng_rdata : '0;
          err_d   = eng_err;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[id_q]) begin
          rr_ptr_d = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: the transaction latch is reset too, because it drives outputs that must read zero.
      state_q  <= IDLE;
      id_q     <= '0;
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rr_ptr_q <= '0;
      timer_q  <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign req_ready   = (state_q == IDLE) ? grant : '0;
  assign rsp_valid   = (state_q == RESP) ? (NUM_REQ'(1) << id_q) : '0;
  assign rsp_rdata   = (state_q == RESP) ? rdata_q : '0;
  assign rsp_err     = (state_q == RESP) && err_q;
  assign eng_s2mm_en = (state_q == ISSUE) && (op_q == OP_WRITE);
  assign eng_mm2s_en = (state_q == ISSUE) && (op_q == OP_READ);
  assign eng_addr    = addr_q;
  assign eng_wdata   = wdata_q;
  assign busy        = (state_q != IDLE);
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Scoreboard bench for dma_req_arbiter: requester driver, mock DDR engine and response checker.
module tb_dma_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TC = 16;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic          err;
    int            acc_cyc;
    int            lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready = '0;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              eng_s2mm_en;
  logic              eng_mm2s_en;
  logic [AW-1:0]     eng_addr;
  logic [DW-1:0]     eng_wdata;
  logic              eng_done = 1'b0;
  logic [DW-1:0]     eng_rdata = '0;
  logic              eng_err = 1'b0;
  logic              busy;
  logic [15:0]       timeout_cnt;

  dma_req_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .eng_s2mm_en(eng_s2mm_en), .eng_mm2s_en(eng_mm2s_en), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_done(eng_done), .eng_rdata(eng_rdata), .eng_err(eng_err),
    .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  req_t          pend[NR][$];
  req_t          cur[NR];
  exp_t          sb[$];
  logic [DW-1:0] exp_mem[logic [AW-1:0]];
  logic [DW-1:0] ddr[logic [AW-1:0]];
  int            grant_log[$];

  logic hang = 1'b0;
  logic err_mode = 1'b0;
  int   eng_lat = 2;
  int   bp_hold = 0;
  int   late_req = 0;
  int   s2mm_pulses = 0;
  int   mm2s_pulses = 0;

  // Mock DDR engine: drives done/rdata/err on the falling edge, eng_lat cycles after the pulse.
  int            e_cnt = 0;
  int            e_late_seen = 0;
  logic          e_op = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;

  initial begin : engine
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      eng_err  = 1'b0;
      if (rst) begin
        e_cnt = 0;
      end else begin
        if (e_cnt > 0) begin
          e_cnt--;
          if (e_cnt == 0) begin
            eng_done = 1'b1;
            eng_err  = err_mode;
            if (e_op) begin
              ddr[e_addr] = e_wdata;
              eng_rdata   = 32'hDEAD_BEEF;
            end else begin
              eng_rdata = ddr.exists(e_addr) ? ddr[e_addr] : '0;
            end
          end
        end
        if (late_req != e_late_seen) begin
          e_late_seen = late_req;
          eng_done    = 1'b1;
          eng_err     = 1'b1;
          eng_rdata   = 32'h5A5A_5A5A;
        end
        if (eng_s2mm_en) s2mm_pulses++;
        if (eng_mm2s_en) mm2s_pulses++;
        if (eng_s2mm_en || eng_mm2s_en) begin
          e_op    = eng_s2mm_en;
          e_addr  = eng_addr;
          e_wdata = eng_wdata;
          if (!hang) e_cnt = eng_lat;
        end
      end
    end
  end

  // Requester driver and scoreboard: expectations pushed at acceptance, popped on rsp_valid.
  logic [NR-1:0] m_drop = '0;
  logic          m_active = 1'b0;
  int            m_hold = 0;
  logic [NR-1:0] m_cap_v = '0;
  logic [DW-1:0] m_cap_d = '0;
  logic          m_cap_e = 1'b0;
  exp_t          m_x;
  exp_t          m_e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      rsp_ready = '0;
      req_valid = req_valid & ~m_drop;
      m_drop    = '0;
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && pend[i].size() > 0) begin
          cur[i]                = pend[i].pop_front();
          req_valid[i]          = 1'b1;
          req_write[i]          = cur[i].wr;
          req_addr[i*AW +: AW]  = cur[i].addr;
          req_wdata[i*DW +: DW] = cur[i].wdata;
        end
      end
      #1;
      if (rst) begin
        sb.delete();
        m_active = 1'b0;
        m_hold   = 0;
      end else begin
        if ((req_valid & req_ready) != '0) begin
          check("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
          for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) begin
              m_x.id      = i;
              m_x.acc_cyc = cyc;
              if (cur[i].addr[1:0] != 2'b00) begin
                m_x.err = 1'b1; m_x.rdata = '0; m_x.lat = 1;
              end else if (hang) begin
                m_x.err = 1'b1; m_x.rdata = '0; m_x.lat = TC + 1;
              end else begin
                m_x.err = err_mode;
                m_x.lat = eng_lat + 2;
                if (cur[i].wr) begin
                  exp_mem[cur[i].addr] = cur[i].wdata;
                  m_x.rdata = '0;
                end else begin
                  m_x.rdata = exp_mem.exists(cur[i].addr) ? exp_mem[cur[i].addr] : '0;
                end
              end
              sb.push_back(m_x);
              grant_log.push_back(i);
              m_drop[i] = 1'b1;
            end
          end
        end
        if (rsp_valid != '0) begin
          if (!m_active) begin
            m_active = 1'b1;
            if (sb.size() == 0) begin
              check("spurious_rsp", 64'(rsp_valid), 64'd0);
            end else begin
              m_e = sb.pop_front();
              check("rsp_id", 64'(rsp_valid), 64'(NR'(1) << m_e.id));
              check("rsp_rdata", 64'(rsp_rdata), 64'(m_e.rdata));
              check("rsp_err", 64'(rsp_err), 64'(m_e.err));
              check("rsp_latency", 64'(cyc - m_e.acc_cyc), 64'(m_e.lat));
            end
            m_cap_v = rsp_valid;
            m_cap_d = rsp_rdata;
            m_cap_e = rsp_err;
            m_hold  = bp_hold;
          end else begin
            check("hold_valid", 64'(rsp_valid), 64'(m_cap_v));
            check("hold_rdata", 64'(rsp_rdata), 64'(m_cap_d));
            check("hold_err", 64'(rsp_err), 64'(m_cap_e));
            check("hold_no_grant", 64'(req_ready), 64'd0);
          end
          if (m_hold > 0) begin
            m_hold--;
            rsp_ready = ~m_cap_v;
          end else begin
            rsp_ready = m_cap_v;
          end
        end else begin
          m_active = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input int id, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.wr = wr; r.addr = a; r.wdata = d;
    pend[id].push_back(r);
  endtask

  function automatic bit all_quiet();
    bit q;
    q = (req_valid == '0) && (sb.size() == 0) && !busy && (rsp_valid == '0);
    for (int i = 0; i < NR; i++) if (pend[i].size() != 0) q = 1'b0;
    return q;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!all_quiet() && n < 3000);
    check({tag, "_drain"}, 64'(n < 3000), 64'd1);
  endtask

  int s0, m0;

  initial begin : main
    rst = 1'b1;
    step(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_s2mm", 64'(eng_s2mm_en), 64'd0);
    check("rst_mm2s", 64'(eng_mm2s_en), 64'd0);
    check("rst_tcnt", 64'(timeout_cnt), 64'd0);
    rst = 1'b0;
    step(2);

    // Fairness: all four requesters continuously valid for two rounds.
    eng_lat = 2;
    grant_log.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++)
        push(i, 1'b1, 32'h2000_0000 + 32'((k * NR + i) * 4), $urandom());
    wait_idle("fair");
    check("fair_count", 64'(grant_log.size()), 64'd8);
    for (int j = 0; j < 8; j++)
      if (j < grant_log.size()) check("fair_order", 64'(grant_log[j]), 64'(j % NR));

    // Single write then read at minimum engine latency.
    eng_lat = 1;
    s0 = s2mm_pulses; m0 = mm2s_pulses;
    push(0, 1'b1, 32'h1000_0000, 32'hABCD_EF01);
    wait_idle("wr");
    push(0, 1'b0, 32'h1000_0000, '0);
    wait_idle("rd");
    check("wr_pulses", 64'(s2mm_pulses - s0), 64'd1);
    check("rd_pulses", 64'(mm2s_pulses - m0), 64'd1);
    eng_lat = 5;
    push(1, 1'b0, 32'h2000_0014, '0);
    wait_idle("rd_lat5");

    // Misaligned read: no engine pulse, error response.
    s0 = s2mm_pulses; m0 = mm2s_pulses;
    push(2, 1'b0, 32'h1000_0002, '0);
    wait_idle("misalign");
    check("mis_s2mm", 64'(s2mm_pulses - s0), 64'd0);
    check("mis_mm2s", 64'(mm2s_pulses - m0), 64'd0);

    // Engine error response.
    eng_lat = 2;
    err_mode = 1'b1;
    push(3, 1'b0, 32'h1000_0000, '0);
    wait_idle("eng_err");
    err_mode = 1'b0;

    // Timeout, then a late done that must be ignored.
    hang = 1'b1;
    push(1, 1'b0, 32'h2000_0004, '0);
    wait_idle("timeout");
    hang = 1'b0;
    check("tcnt_one", 64'(timeout_cnt), 64'd1);
    late_req++;
    step(3);
    check("late_tcnt", 64'(timeout_cnt), 64'd1);
    check("late_busy", 64'(busy), 64'd0);
    push(1, 1'b0, 32'h2000_0004, '0);
    wait_idle("after_timeout");

    // Response backpressure with a competing requester waiting.
    eng_lat = 3;
    bp_hold = 10;
    push(3, 1'b0, 32'h2000_0008, '0);
    push(0, 1'b0, 32'h1000_0000, '0);
    wait_idle("backpressure");
    bp_hold = 0;

    // Reset while waiting on the engine.
    hang = 1'b1;
    push(1, 1'b0, 32'h2000_000C, '0);
    step(5);
    check("pre_rst_busy", 64'(busy), 64'd1);
    push(3, 1'b0, 32'h2000_0000, '0);
    push(0, 1'b0, 32'h1000_0000, '0);
    step(2);
    rst = 1'b1;
    step(1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("mid_rst_rsp_err", 64'(rsp_err), 64'd0);
    check("mid_rst_s2mm", 64'(eng_s2mm_en), 64'd0);
    check("mid_rst_mm2s", 64'(eng_mm2s_en), 64'd0);
    check("mid_rst_eng_addr", 64'(eng_addr), 64'd0);
    check("mid_rst_tcnt", 64'(timeout_cnt), 64'd0);
    check("mid_rst_grant", 64'(req_ready), 64'b0001);
    hang = 1'b0;
    grant_log.delete();
    rst = 1'b0;
    wait_idle("after_rst");
    check("after_rst_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      check("after_rst_first", 64'(grant_log[0]), 64'd0);
      check("after_rst_second", 64'(grant_log[1]), 64'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
